// File: rtl/triad_pkg.sv
// Shared definitions for the triad stream arbiter: triad word layout and
// the grant FSM state encoding.
package triad_pkg;

    // Triad word: {pulse_id_2, pulse_id_1, pulse_id_0, polynomial}
    localparam int TRIAD_W  = 68;
    localparam int FIELD_W  = 17;
    localparam int POLY_LSB = 0;
    localparam int PID0_LSB = 17;
    localparam int PID1_LSB = 34;
    localparam int PID2_LSB = 51;

    // Grant FSM: IDLE looks for a pending face, PRESENT holds the word
    // on the output port until the consumer takes it.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/triad_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after last_grant, wrapping modulo N, so last_grant itself is
// considered last.
module triad_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;

    // Scan offsets 1..N from last_grant; the first request hit wins.
    always_comb begin
        found      = 1'b0;
        index      = {IDX_W{1'b0}};
        cand_s     = 0;
        cand_idx_s = {IDX_W{1'b0}};
        for (int i = 1; i <= N; i++) begin
            cand_s     = (int'(last_grant) + i) % N;
            cand_idx_s = IDX_W'(cand_s);
            if (!found && req[cand_idx_s]) begin
                found = 1'b1;
                index = cand_idx_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/triad_stream_arbiter.sv
// Shares one downstream triad consumer between N per-face triad managers.
// Each face has a one-word slot; pending faces are granted round-robin
// onto a valid/ready port and the granted face gets a one-cycle re-arm
// pulse once its word is taken. Overruns are flagged and counted.
module triad_stream_arbiter
    import triad_pkg::*;
#(
    parameter  int N_TRIADS = 4,
    localparam int FACE_W   = $clog2(N_TRIADS)
) (
    input  logic                         clk_96MHz,
    input  logic                         reset,
    input  logic [N_TRIADS*TRIAD_W-1:0]  triad_data_in,
    input  logic [N_TRIADS-1:0]          triad_data_avl_in,
    output logic [TRIAD_W-1:0]           out_data,
    output logic [FACE_W-1:0]            out_face,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_TRIADS-1:0]          reset_pulse_identifier,
    input  logic                         clear_flags,
    output logic [N_TRIADS-1:0]          overrun_flags,
    output logic [7:0]                   drop_count,
    output logic                         state_led
);

    arb_state_e             state_q, state_d;
    logic [N_TRIADS-1:0]    slot_valid_q, slot_valid_d;
    logic [TRIAD_W-1:0]     slot_data_q [N_TRIADS];
    logic [TRIAD_W-1:0]     slot_data_d [N_TRIADS];
    logic [FACE_W-1:0]      last_grant_q, last_grant_d;
    logic [TRIAD_W-1:0]     out_data_q, out_data_d;
    logic [FACE_W-1:0]      out_face_q, out_face_d;
    logic                   out_valid_q, out_valid_d;
    logic [N_TRIADS-1:0]    pulse_q, pulse_d;
    logic [N_TRIADS-1:0]    flags_q, flags_d;
    logic [7:0]             drop_count_q, drop_count_d;
    logic                   led_q, led_d;

    logic                   consume_s;
    logic [N_TRIADS-1:0]    drop_vec_s;
    logic [8:0]             drop_sum_s;
    logic [8:0]             count_sum_s;
    logic [7:0]             count_base_s;
    logic [N_TRIADS-1:0]    flags_base_s;
    logic                   pick_found_s;
    logic [FACE_W-1:0]      pick_idx_s;

    triad_rr_picker #(
        .N     (N_TRIADS),
        .IDX_W (FACE_W)
    ) u_picker (
        .req        (slot_valid_q),
        .last_grant (last_grant_q),
        .found      (pick_found_s),
        .index      (pick_idx_s)
    );

    // The presented word is taken this cycle (out_ready ignored otherwise).
    always_comb begin
        consume_s = (state_q == PRESENT) && out_valid_q && out_ready;
    end

    // Per-face slot capture/drop, then overrun flag and saturating counter update.
    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        drop_vec_s   = {N_TRIADS{1'b0}};
        drop_sum_s   = 9'd0;
        for (int k = 0; k < N_TRIADS; k++) begin
            if (triad_data_avl_in[k]) begin
                // A slot being consumed this cycle frees up for the new word.
                if (!slot_valid_q[k] || (consume_s && (out_face_q == FACE_W'(k)))) begin
                    slot_valid_d[k] = 1'b1;
                    slot_data_d[k]  = triad_data_in[k*TRIAD_W +: TRIAD_W];
                end else begin
                    drop_vec_s[k] = 1'b1;
                    drop_sum_s    = drop_sum_s + 9'd1;
                end
            end else if (consume_s && (out_face_q == FACE_W'(k))) begin
                slot_valid_d[k] = 1'b0;
            end else begin
                slot_valid_d[k] = slot_valid_q[k];
            end
        end

        // Clearing takes effect first so a simultaneous drop still registers.
        if (clear_flags) begin
            flags_base_s = {N_TRIADS{1'b0}};
            count_base_s = 8'd0;
        end else begin
            flags_base_s = flags_q;
            count_base_s = drop_count_q;
        end
        flags_d     = flags_base_s | drop_vec_s;
        count_sum_s = {1'b0, count_base_s} + drop_sum_s;
        if (count_sum_s > 9'd255) begin
            drop_count_d = 8'd255;
        end else begin
            drop_count_d = count_sum_s[7:0];
        end
        led_d = |flags_d;
    end

    // Grant FSM: pick a pending face in IDLE, hold it in PRESENT until taken.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_face_d   = out_face_q;
        out_valid_d  = out_valid_q;
        pulse_d      = {N_TRIADS{1'b0}};
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    out_data_d   = slot_data_q[pick_idx_s];
                    out_face_d   = pick_idx_s;
                    out_valid_d  = 1'b1;
                    last_grant_d = pick_idx_s;
                    state_d      = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (consume_s) begin
                    out_valid_d          = 1'b0;
                    pulse_d[out_face_q]  = 1'b1;
                    state_d              = IDLE;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state_q      <= IDLE;
            slot_valid_q <= {N_TRIADS{1'b0}};
            for (int k = 0; k < N_TRIADS; k++) begin
                slot_data_q[k] <= {TRIAD_W{1'b0}};
            end
            last_grant_q <= FACE_W'(N_TRIADS - 1);
            out_data_q   <= {TRIAD_W{1'b0}};
            out_face_q   <= {FACE_W{1'b0}};
            out_valid_q  <= 1'b0;
            pulse_q      <= {N_TRIADS{1'b0}};
            flags_q      <= {N_TRIADS{1'b0}};
            drop_count_q <= 8'd0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_face_q   <= out_face_d;
            out_valid_q  <= out_valid_d;
            pulse_q      <= pulse_d;
            flags_q      <= flags_d;
            drop_count_q <= drop_count_d;
            led_q        <= led_d;
        end
    end

    assign out_data               = out_data_q;
    assign out_face               = out_face_q;
    assign out_valid              = out_valid_q;
    assign reset_pulse_identifier = pulse_q;
    assign overrun_flags          = flags_q;
    assign drop_count             = drop_count_q;
    assign state_led              = led_q;

endmodule

// File: tb/tb_triad_stream_arbiter.sv
// Directed self-checking bench for triad_stream_arbiter (4 faces).
module tb_triad_stream_arbiter;

    localparam int N  = 4;
    localparam int TW = 68;

    logic            clk_96MHz;
    logic            reset;
    logic [N*TW-1:0] triad_data_in;
    logic [N-1:0]    triad_data_avl_in;
    logic [TW-1:0]   out_data;
    logic [1:0]      out_face;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    reset_pulse_identifier;
    logic            clear_flags;
    logic [N-1:0]    overrun_flags;
    logic [7:0]      drop_count;
    logic            state_led;

    int checks;
    int failures;

    logic [TW-1:0] w [4];

    triad_stream_arbiter #(.N_TRIADS(N)) dut (
        .clk_96MHz              (clk_96MHz),
        .reset                  (reset),
        .triad_data_in          (triad_data_in),
        .triad_data_avl_in      (triad_data_avl_in),
        .out_data               (out_data),
        .out_face               (out_face),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .reset_pulse_identifier (reset_pulse_identifier),
        .clear_flags            (clear_flags),
        .overrun_flags          (overrun_flags),
        .drop_count             (drop_count),
        .state_led              (state_led)
    );

    initial clk_96MHz = 1'b0;
    always #5 clk_96MHz = ~clk_96MHz;

    task automatic tick();
        @(posedge clk_96MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [TW-1:0] val);
        triad_data_in[k*TW +: TW] = val;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        triad_data_in = '0;
        triad_data_avl_in = 4'b0000;
        out_ready = 1'b0;
        clear_flags = 1'b0;
        w[0] = 68'hA_1111_2222_3333_4444;
        w[1] = 68'hB_5555_6666_7777_8888;
        w[2] = 68'hC_9999_AAAA_BBBB_CCCC;
        w[3] = 68'hD_DDDD_EEEE_FFFF_0123;

        // Reset values
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 68'h0);
        chk("rst_face", out_face, 2'd0);
        chk("rst_pulse", reset_pulse_identifier, 4'b0000);
        chk("rst_flags", overrun_flags, 4'b0000);
        chk("rst_drop", drop_count, 8'd0);
        chk("rst_led", state_led, 1'b0);

        // Single word on face 2, consumer ready
        out_ready = 1'b1;
        set_word(2, 68'h0_0001_0002_0003_0ABC);
        triad_data_avl_in = 4'b0100;
        tick();
        triad_data_avl_in = 4'b0000;
        chk("t1_valid_lat1", out_valid, 1'b0);
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_face", out_face, 2'd2);
        chk("t1_data", out_data, 68'h0_0001_0002_0003_0ABC);
        tick();
        chk("t1_valid_drop", out_valid, 1'b0);
        chk("t1_pulse", reset_pulse_identifier, 4'b0100);
        tick();
        chk("t1_pulse_end", reset_pulse_identifier, 4'b0000);

        // All four faces at once after a fresh reset: grants 0,1,2,3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) set_word(k, w[k]);
        triad_data_avl_in = 4'b1111;
        tick();
        triad_data_avl_in = 4'b0000;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("t2_valid", out_valid, 1'b1);
            chk("t2_face", out_face, g[1:0]);
            chk("t2_data", out_data, w[g]);
            chk("t2_pulse_low", reset_pulse_identifier, 4'b0000);
            tick();
            chk("t2_gap", out_valid, 1'b0);
            chk("t2_pulse", reset_pulse_identifier, 4'b0001 << g);
        end
        chk("t2_drop", drop_count, 8'd0);

        // Overrun on face 1 while it is presented and stalled
        out_ready = 1'b0;
        set_word(1, w[1]);
        triad_data_avl_in = 4'b0010;
        tick();
        triad_data_avl_in = 4'b0000;
        tick();
        chk("t3_face", out_face, 2'd1);
        set_word(1, w[2]);
        triad_data_avl_in = 4'b0010;
        tick();
        set_word(1, w[3]);
        tick();
        triad_data_avl_in = 4'b0000;
        chk("t3_data_held", out_data, w[1]);
        chk("t3_flags", overrun_flags, 4'b0010);
        chk("t3_drop", drop_count, 8'd2);
        chk("t3_led", state_led, 1'b1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t3_clr_flags", overrun_flags, 4'b0000);
        chk("t3_clr_drop", drop_count, 8'd0);
        chk("t3_clr_led", state_led, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("t3_pulse", reset_pulse_identifier, 4'b0010);
        tick();

        // Capture on consume for face 0
        out_ready = 1'b0;
        set_word(0, w[0]);
        triad_data_avl_in = 4'b0001;
        tick();
        triad_data_avl_in = 4'b0000;
        tick();
        chk("t4_face", out_face, 2'd0);
        chk("t4_data1", out_data, w[0]);
        out_ready = 1'b1;
        set_word(0, w[3]);
        triad_data_avl_in = 4'b0001;
        tick();
        triad_data_avl_in = 4'b0000;
        chk("t4_valid_low", out_valid, 1'b0);
        chk("t4_pulse", reset_pulse_identifier, 4'b0001);
        chk("t4_nodrop", drop_count, 8'd0);
        chk("t4_noflag", overrun_flags, 4'b0000);
        tick();
        chk("t4_valid2", out_valid, 1'b1);
        chk("t4_face2", out_face, 2'd0);
        chk("t4_data2", out_data, w[3]);
        tick();
        chk("t4_pulse2", reset_pulse_identifier, 4'b0001);

        // Reset while presenting
        out_ready = 1'b0;
        set_word(2, w[2]);
        set_word(3, w[3]);
        triad_data_avl_in = 4'b1100;
        tick();
        triad_data_avl_in = 4'b0000;
        tick();
        chk("t5_pre_valid", out_valid, 1'b1);
        chk("t5_pre_face", out_face, 2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_valid", out_valid, 1'b0);
        chk("t5_pulse", reset_pulse_identifier, 4'b0000);
        out_ready = 1'b1;
        tick(); tick();
        chk("t5_empty", out_valid, 1'b0);
        set_word(0, w[0]);
        triad_data_avl_in = 4'b1001;
        tick();
        triad_data_avl_in = 4'b0000;
        tick();
        chk("t5_first_face", out_face, 2'd0);
        chk("t5_first_data", out_data, w[0]);
        tick();
        chk("t5_first_pulse", reset_pulse_identifier, 4'b0001);
        tick();
        chk("t5_second_face", out_face, 2'd3);
        tick();
        out_ready = 1'b0;

        // 300 drops saturate the counter
        for (int k = 0; k < 4; k++) set_word(k, w[k]);
        triad_data_avl_in = 4'b1111;
        tick();
        tick();
        chk("t6_drop4", drop_count, 8'd4);
        chk("t6_flags", overrun_flags, 4'b1111);
        for (int i = 0; i < 74; i++) tick();
        triad_data_avl_in = 4'b0000;
        chk("t6_sat", drop_count, 8'd255);
        chk("t6_led", state_led, 1'b1);
        chk("t6_data", out_data, w[0]);
        clear_flags = 1'b1;
        triad_data_avl_in = 4'b0010;
        tick();
        clear_flags = 1'b0;
        triad_data_avl_in = 4'b0000;
        chk("t6_clr_drop_flags", overrun_flags, 4'b0010);
        chk("t6_clr_drop_count", drop_count, 8'd1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("t6_final_count", drop_count, 8'd0);
        chk("t6_final_led", state_led, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/triad_stream_arbiter.md
# triad_stream_arbiter

Shares one downstream triad consumer (the data parser / upload path) between several triad managers, one per tracker face. Each manager emits a 68-bit triad word with a one-cycle available strobe; this block buffers one word per face, picks among pending faces round-robin, presents the winner on a valid/ready port, and pulses that face's pulse-identifier reset once the word is taken. It sits between the per-face triad managers and the single data parser.

## Interface
- N_TRIADS, 4, number of requesting triad managers (2..8)
- TRIAD_W, 68, triad word width: {pulse_id_2, pulse_id_1, pulse_id_0, polynomial}, 17 bits each
- clk_96MHz  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- triad_data_in  in  N_TRIADS*TRIAD_W  face k word at bits [k*TRIAD_W +: TRIAD_W]
- triad_data_avl_in  in  N_TRIADS  one-cycle strobe per face; word valid only in that cycle
- out_data  out  TRIAD_W  granted triad word
- out_face  out  clog2(N_TRIADS)  index of granting face
- out_valid  out  1  out_data/out_face valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- reset_pulse_identifier  out  N_TRIADS  one-cycle re-arm pulse to face k's pulse identifier
- clear_flags  in  1  clears overrun flags and drop counter
- overrun_flags  out  N_TRIADS  sticky: face k dropped a word
- drop_count  out  8  saturating count of dropped words, all faces
- state_led  out  1  high while any overrun flag set

## Operation
- Per face k: one slot (slot_valid[k], slot_data[k]).
  - Strobe while slot empty: capture word, slot_valid[k] <= 1.
  - Strobe while slot full and not being consumed this cycle: new word dropped, old kept; overrun_flags[k] <= 1; drop_count += 1 (saturates at 255).
  - Strobe in the same cycle face k is consumed: new word captured, slot stays valid, no overrun.
  - Several strobes in one cycle: each handled independently; drop_count adds the number of drops, saturating.
- FSM states:
  - IDLE: if any slot_valid, pick face = first valid index searching from last_grant+1 upward, wrapping modulo N_TRIADS. Load out_data/out_face from the slot, out_valid <= 1, last_grant <= face, go PRESENT. Otherwise stay.
  - PRESENT: hold out_data/out_face/out_valid stable. On out_valid && out_ready: clear slot_valid[face] (unless re-captured per rule above), out_valid <= 0, reset_pulse_identifier[face] <= 1 for exactly one cycle, go IDLE.
- Slot contents of the granted face may not change while in PRESENT, except the capture-on-consume case, which loads the slot for the next round, not out_data.
- clear_flags: overrun_flags <= 0, drop_count <= 0. A drop in the same cycle wins: flag set, count = 1.
- reset: all slots empty, FSM IDLE, last_grant = N_TRIADS-1 so face 0 wins first. Outputs after reset: out_valid 0, out_data 0, out_face 0, reset_pulse_identifier 0, overrun_flags 0, drop_count 0, state_led 0. Reset mid-PRESENT abandons the word with no re-arm pulse.

## Timing
- Strobe at edge t: slot valid after t; IDLE grants at t+1; out_valid high after t+1 (2-cycle latency when idle).
- Handshake at edge h: out_valid low and re-arm pulse high after h; pulse low after h+1; next grant at h+1, so out_valid can return after h+1.
- Peak throughput: one word per 2 cycles. out_valid is never asserted in consecutive words without an intervening low cycle.
- out_ready is ignored while out_valid = 0. No combinational path from out_ready to any output.
- Fairness: with all faces pending continuously, grants rotate 0,1,2,3,0,...

## Structure
- Shared package triad_pkg: TRIAD_W = 68, field offsets POLY_LSB = 0, PID0_LSB = 17, PID1_LSB = 34, PID2_LSB = 51, field width 17, and the FSM state encoding (IDLE, PRESENT).
- Sub-module triad_rr_picker: combinational round-robin picker. Inputs are the request vector and last_grant; outputs are found and index. This is the only sub-module.

## Test plan
- After reset, strobe face 2 with word 68'h0_0001_0002_0003_0ABC and out_ready = 1: out_valid high 2 cycles later, out_face = 2, data matches; reset_pulse_identifier = 4'b0100 for one cycle after the handshake.
- Strobe all 4 faces in one cycle, out_ready = 1: grants in order 0,1,2,3, one word every 2 cycles, 4 re-arm pulses, drop_count = 0.
- Hold out_ready = 0 with face 1 presented; strobe face 1 twice more: out_data unchanged, overrun_flags = 4'b0010, drop_count = 2, state_led = 1; clear_flags returns both to 0.
- Strobe face 0 in the same cycle its pending word is accepted: no drop, and a second face-0 grant carries the new word.
- Assert reset while in PRESENT: next cycle out_valid = 0, all slots empty, no re-arm pulse; the next grant goes to face 0 first.
- 300 drops with no clear_flags: drop_count saturates at 255.
